vec_store_unit: RTL and testbench
=================================

# vec_store_unit

Write-back stage directly upstream of `out_mem`. Accepts 4-lane, 32-bit vector results from the vector datapath over a valid/ready handshake and buffers them in a small FIFO. Drains the FIFO into `out_mem` one vector per cycle, driving `we`, `addr` and `wd1..wd4` with an auto-incrementing byte address. Signals completion once a program's results are fully committed.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `BASE_ADDR`, 32'h0: first write address after `start`.
- `ADDR_STEP`, 32'd4: address increment per committed vector.
- `ADDR_LIMIT`, 32'd1024: first address that must not be written.
- `clk` in 1: system clock, all flops on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; opens a new store session.
- `finish` in 1: one-cycle pulse; no more vectors for this session.
- `in_valid` in 1: `in_d0..in_d3` hold a vector.
- `in_ready` out 1: unit accepts a vector this cycle.
- `in_d0`, `in_d1`, `in_d2`, `in_d3` in 32 each: lanes 0–3.
- `we` out 1: write strobe to `out_mem`.
- `addr` out 32: write address to `out_mem`.
- `wd1`, `wd2`, `wd3`, `wd4` out 32 each: lanes 0–3 to `out_mem`.
- `busy` out 1: session open or FIFO non-empty.
- `done` out 1: one-cycle pulse when the session has fully drained.
- `overflow` out 1: sticky; a vector was dropped at `ADDR_LIMIT`.
- `count` out 32: vectors committed in the current session.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `in_ready`=0.
  - `start` → RUN; on the same edge load the address pointer with `BASE_ADDR` and clear `count` and `overflow`.
- RUN:
  - `in_ready` = (FIFO occupancy < DEPTH). No combinational bypass from pop to `in_ready`.
  - A push occurs on `in_valid & in_ready`.
  - `finish` → DRAIN. A vector pushed on the same edge as `finish` is kept.
- DRAIN:
  - `in_ready`=0.
  - Leave for DONE on the edge where the FIFO is empty and no write is pending.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Pop / write (RUN and DRAIN):
  - Whenever the FIFO is non-empty, pop the head every cycle.
  - If pointer < `ADDR_LIMIT`:
    - Register `we`=1, `addr`=pointer, `wd1..wd4`=head lanes 0..3.
    - Pointer += `ADDR_STEP`.
    - `count` += 1.
  - Otherwise: `we`=0, set `overflow`, vector discarded.
  - If no pop: `we`=0. `addr` and `wd*` hold their last values.
- Simultaneous push and pop: occupancy unchanged. FIFO full plus pop: `in_ready` remains 0 that cycle and rises the next cycle.
- Pointer arithmetic is 32-bit unsigned. The `ADDR_LIMIT` check prevents wrap past the limit; the pointer never wraps to 0 inside a session.
- `start` outside IDLE is ignored. `finish` outside RUN is ignored.
- `rst` at any time:
  - FIFO emptied, state IDLE.
  - In-flight vectors are lost and no partial write completes.

## Timing
- Reset values:
  - `in_ready`=0, `we`=0, `addr`=0, `wd1..wd4`=0.
  - `busy`=0, `done`=0, `overflow`=0, `count`=0.
  - Pointer = `BASE_ADDR`.
- All outputs are registered except `in_ready`, which is decoded from state and occupancy registers only.
- Latency (push at edge k into an empty FIFO):
  - `we`/`addr`/`wd*` valid from edge k+1 to edge k+2.
  - `out_mem` samples the write at edge k+2.
- Throughput: one vector per cycle sustained; FIFO never fills at a steady 1/cycle input.
- Session end (`finish` at edge f, FIFO holding n entries, no further pushes):
  - Last `we` high in cycle f+n.
  - `done` high in cycle f+n+1.
  - `busy` low from edge f+n+2.
- `busy` rises on the `start` edge.

## Test plan
- Reset, then `start`, then one vector {15,45,74,82}, then `finish`:
  - One `we` pulse with `addr`=0 and `wd1..4`=15,45,74,82.
  - `done` two cycles after `finish`; `count`=1.
- Two back-to-back vectors {15,45,74,82} and {16,46,76,86}:
  - Consecutive `we` cycles at `addr` 0 then 4.
  - Reading `out_mem` at addr 0 and 4 afterwards returns those lanes.
- Memory stall model: 6 vectors presented with `in_valid` held high:
  - `in_ready` never drops.
  - Writes land at addresses 0–20 in order; `count`=6.
- `ADDR_LIMIT`=8 with 3 vectors:
  - Writes at 0 and 4 only.
  - `overflow`=1, `count`=2.
  - `done` still pulses.
- Assert `rst` in the middle of a 3-vector session:
  - `we` drops immediately; all outputs return to reset values.
  - A subsequent `start` writes again from `BASE_ADDR`.
- `finish` on the same edge as the last push, with `start` pulsed during DRAIN:
  - The last vector is written.
  - The `start` pulse is ignored.
  - Exactly one `done` pulse.

Source files
------------

// File: rtl/vec_store_unit_if.sv
// Vector input handshake (in_valid/in_ready) plus the out_mem write bus and status.
// in_valid/in_ready: a vector transfers on every rising edge where both are high.
interface vec_store_unit_if;
    logic        start;
    logic        finish;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_d0;
    logic [31:0] in_d1;
    logic [31:0] in_d2;
    logic [31:0] in_d3;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd1;
    logic [31:0] wd2;
    logic [31:0] wd3;
    logic [31:0] wd4;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] count;

    modport master (
        output start, finish, in_valid, in_d0, in_d1, in_d2, in_d3,
        input  in_ready, we, addr, wd1, wd2, wd3, wd4, busy, done, overflow, count
    );

    modport slave (
        input  start, finish, in_valid, in_d0, in_d1, in_d2, in_d3,
        output in_ready, we, addr, wd1, wd2, wd3, wd4, busy, done, overflow, count
    );
endinterface

// File: rtl/vec_store_unit.sv
// Write-back stage: buffers 4-lane vectors in a FIFO and drains one per cycle
// into out_mem at an auto-incrementing address, pulsing done when a session drains.
module vec_store_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [31:0] ADDR_STEP  = 32'd4,
    parameter logic [31:0] ADDR_LIMIT = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    vec_store_unit_if.slave   bus,
    output logic [1:0]        dbg_state
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic [127:0]  mem [DEPTH];
    logic [127:0]  head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [31:0]   ptr;
    logic          push;
    logic          pop;

    // in_ready comes from registers only, so a pop never frees a slot in the same cycle.
    assign bus.in_ready = (state == RUN) && (occ < DEPTH_W);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = ((state == RUN) || (state == DRAIN)) && (occ != '0);
    assign head         = mem[rd_ptr];
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_d3, bus.in_d2, bus.in_d1, bus.in_d0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            ptr          <= BASE_ADDR;
            bus.we       <= 1'b0;
            bus.addr     <= '0;
            bus.wd1      <= '0;
            bus.wd2      <= '0;
            bus.wd3      <= '0;
            bus.wd4      <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.count    <= '0;
        end else begin
            bus.we   <= 1'b0;
            bus.done <= 1'b0;
            occ      <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            // Past the limit the vector is still popped, only the write is suppressed.
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (ptr < ADDR_LIMIT) begin
                    bus.we    <= 1'b1;
                    bus.addr  <= ptr;
                    bus.wd1   <= head[31:0];
                    bus.wd2   <= head[63:32];
                    bus.wd3   <= head[95:64];
                    bus.wd4   <= head[127:96];
                    ptr       <= ptr + ADDR_STEP;
                    bus.count <= bus.count + 32'd1;
                end else begin
                    bus.overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= RUN;
                        bus.busy     <= 1'b1;
                        ptr          <= BASE_ADDR;
                        bus.count    <= '0;
                        bus.overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.finish) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Empty here means the last write is already on the bus this cycle.
                    if (occ == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_store_unit.sv
// Bench for vec_store_unit: two instances (address limit 1024 and 8) share one
// stimulus stream; each is checked every cycle against a queue-based session model.
module tb_vec_store_unit;
  typedef enum {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic [31:0] in_d0, in_d1, in_d2, in_d3;

  int checks = 0;
  int errors = 0;
  bit ready_wait_seen;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- DUTs, model and compare per instance ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam logic [31:0] LIM = (gi == 0) ? 32'd1024 : 32'd8;

    vec_store_unit_if ifc ();
    logic [1:0] dbg;

    assign ifc.start    = start;
    assign ifc.finish   = finish;
    assign ifc.in_valid = in_valid;
    assign ifc.in_d0    = in_d0;
    assign ifc.in_d1    = in_d1;
    assign ifc.in_d2    = in_d2;
    assign ifc.in_d3    = in_d3;

    vec_store_unit #(
      .DEPTH(4), .BASE_ADDR(32'h0), .ADDR_STEP(32'd4), .ADDR_LIMIT(LIM)
    ) dut (
      .clk(clk), .rst(rst), .bus(ifc), .dbg_state(dbg)
    );

    phase_t       ph;
    logic [127:0] exp_q[$];
    logic [127:0] act_mem [logic [31:0]];
    logic [31:0]  m_ptr, m_count, m_addr;
    logic [127:0] m_wd;
    logic         m_we, m_done, m_ovf, m_busy;
    int           done_cnt;

    // Session model: queue of pending vectors, one popped per cycle while a session is live.
    always @(posedge clk or posedge rst) begin
      int n;
      bit can_push;
      logic [127:0] h;
      if (rst) begin
        ph = P_IDLE; exp_q.delete();
        m_ptr = 0; m_count = 0; m_addr = 0; m_wd = 0;
        m_we = 0; m_done = 0; m_ovf = 0; m_busy = 0;
      end else begin
        n = exp_q.size();
        can_push = (ph == P_RUN) && (n < 4);
        m_we = 0;
        m_done = 0;
        if ((ph == P_RUN || ph == P_DRAIN) && n > 0) begin
          h = exp_q.pop_front();
          if (m_ptr < LIM) begin
            m_we = 1; m_addr = m_ptr; m_wd = h;
            m_ptr = m_ptr + 4; m_count = m_count + 1;
          end else m_ovf = 1;
        end
        case (ph)
          P_IDLE:  if (start) begin ph = P_RUN; m_ptr = 0; m_count = 0; m_ovf = 0; end
          P_RUN:   if (finish) ph = P_DRAIN;
          P_DRAIN: if (n == 0) begin ph = P_DONE; m_done = 1; end
          default: ph = P_IDLE;
        endcase
        m_busy = (ph != P_IDLE);
        if (can_push && in_valid) exp_q.push_back({in_d3, in_d2, in_d1, in_d0});
      end
    end

    always @(negedge clk) begin
      string p;
      p = $sformatf("u%0d_", gi);
      check({p, "in_ready"}, ifc.in_ready, (ph == P_RUN) && (exp_q.size() < 4));
      check({p, "we"},       ifc.we,       m_we);
      check({p, "addr"},     ifc.addr,     m_addr);
      check({p, "wd"},       {ifc.wd4, ifc.wd3, ifc.wd2, ifc.wd1}, m_wd);
      check({p, "busy"},     ifc.busy,     m_busy);
      check({p, "done"},     ifc.done,     m_done);
      check({p, "overflow"}, ifc.overflow, m_ovf);
      check({p, "count"},    ifc.count,    m_count);
      if (ifc.we === 1'b1) act_mem[ifc.addr] = {ifc.wd4, ifc.wd3, ifc.wd2, ifc.wd1};
      if (ifc.done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_log();
    g[0].act_mem.delete();
    g[1].act_mem.delete();
    g[0].done_cnt = 0;
    g[1].done_cnt = 0;
    ready_wait_seen = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic send_vec(input logic [127:0] v, input bit fin);
    int t;
    t = 0;
    in_valid = 1'b1;
    {in_d3, in_d2, in_d1, in_d0} = v;
    while (g[0].ifc.in_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    if (t > 0) ready_wait_seen = 1;
    check("send_ready", g[0].ifc.in_ready, 1'b1);
    finish = fin;
    step();
    in_valid = 1'b0;
    finish = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (g[0].ifc.busy !== 1'b0 && t < 60) begin
      step();
      t++;
    end
    check("wait_idle", g[0].ifc.busy, 1'b0);
    step();
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    logic [127:0] v1, v2, vr;
    rst = 1'b1; start = 0; finish = 0; in_valid = 0;
    in_d0 = 0; in_d1 = 0; in_d2 = 0; in_d3 = 0;
    v1 = {32'd82, 32'd74, 32'd45, 32'd15};
    v2 = {32'd86, 32'd76, 32'd46, 32'd16};

    // Reset values
    step();
    step();
    check("rst_we", g[0].ifc.we, 1'b0);
    check("rst_addr", g[0].ifc.addr, 32'd0);
    check("rst_count", g[0].ifc.count, 32'd0);
    check("rst_busy", g[0].ifc.busy, 1'b0);
    check("rst_in_ready", g[0].ifc.in_ready, 1'b0);
    rst = 1'b0;
    step();

    // Single vector session
    clear_log();
    pulse_start();
    check("start_busy", g[0].ifc.busy, 1'b1);
    send_vec(v1, 0);
    pulse_finish();
    wait_idle();
    check("t1_mem0", g[0].act_mem[32'd0], v1);
    check("t1_count", g[0].ifc.count, 32'd1);
    check("t1_done_cnt", g[0].done_cnt, 1);

    // Two back-to-back vectors
    do_reset();
    clear_log();
    pulse_start();
    send_vec(v1, 0);
    send_vec(v2, 1);
    wait_idle();
    check("t2_mem0", g[0].act_mem[32'd0], v1);
    check("t2_mem4", g[0].act_mem[32'd4], v2);
    check("t2_count", g[0].ifc.count, 32'd2);

    // Six vectors with valid held high; limit-8 instance sees 3 of interest
    clear_log();
    pulse_start();
    for (int i = 0; i < 6; i++) send_vec({32'(i * 4 + 3), 32'(i * 4 + 2), 32'(i * 4 + 1), 32'(i * 4)}, i == 5);
    wait_idle();
    check("t3_ready_held", ready_wait_seen, 1'b0);
    check("t3_count", g[0].ifc.count, 32'd6);
    check("t3_mem20", g[0].act_mem[32'd20], {32'd23, 32'd22, 32'd21, 32'd20});
    check("t3_mem0", g[0].act_mem[32'd0], {32'd3, 32'd2, 32'd1, 32'd0});
    check("lim_count", g[1].ifc.count, 32'd2);
    check("lim_overflow", g[1].ifc.overflow, 1'b1);
    check("lim_mem4", g[1].act_mem[32'd4], {32'd7, 32'd6, 32'd5, 32'd4});
    check("lim_no_mem8", g[1].act_mem.exists(32'd8), 1'b0);
    check("lim_done_cnt", g[1].done_cnt, 1);

    // Reset in the middle of a session
    clear_log();
    pulse_start();
    send_vec(v1, 0);
    send_vec(v2, 0);
    rst = 1'b1;
    #1;
    check("midrst_we", g[0].ifc.we, 1'b0);
    check("midrst_count", g[0].ifc.count, 32'd0);
    check("midrst_addr", g[0].ifc.addr, 32'd0);
    step();
    rst = 1'b0;
    clear_log();
    pulse_start();
    send_vec(v2, 1);
    wait_idle();
    check("midrst_restart_mem0", g[0].act_mem[32'd0], v2);

    // finish with the last push, start pulsed during DRAIN
    clear_log();
    pulse_start();
    send_vec(v1, 1);
    pulse_start();
    wait_idle();
    check("t6_mem0", g[0].act_mem[32'd0], v1);
    check("t6_done_cnt", g[0].done_cnt, 1);
    check("t6_count", g[0].ifc.count, 32'd1);

    // Random traffic, including stray start/finish and occasional reset
    for (int c = 0; c < 3000; c++) begin
      vr = {$urandom(), $urandom(), $urandom(), $urandom()};
      start    = ($urandom_range(0, 9) == 0);
      finish   = ($urandom_range(0, 11) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 299) == 0);
      {in_d3, in_d2, in_d1, in_d0} = vr;
      step();
    end
    rst = 0; start = 0; finish = 0; in_valid = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
